// File: rtl/cozy_mem_arbiter.sv
// Two-port arbiter in front of the single-port cozy_memory word RAM.
// A CPU read/write port and a video read port share the memory; the granted port is acked one cycle later.
module cozy_mem_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter bit VID_FIXED  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    input  logic [1:0]            cpu_bwe,
    output logic                  cpu_ack,
    output logic [15:0]           cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [15:0]           vid_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    output logic [1:0]            mem_bwe,
    input  logic [15:0]           mem_dout
);

    logic                  cpu_ack_q, cpu_ack_d;
    logic                  vid_ack_q, vid_ack_d;
    logic                  last_vid_q, last_vid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cpu_elig, vid_elig;
    logic                  grant_cpu, grant_vid;

    always_comb begin
        // a port's request is still high in its own ack cycle, so it sits out that cycle
        cpu_elig  = cpu_req & ~cpu_ack_q;
        vid_elig  = vid_req & ~vid_ack_q;
        grant_cpu = 1'b0;
        grant_vid = 1'b0;
        if (cpu_elig && vid_elig) begin
            if (VID_FIXED || !last_vid_q) begin
                grant_vid = 1'b1;
            end else begin
                grant_cpu = 1'b1;
            end
        end else begin
            grant_cpu = cpu_elig;
            grant_vid = vid_elig;
        end

        mem_addr = addr_q;
        mem_din  = '0;
        mem_bwe  = '0;
        if (grant_cpu) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_wdata;
            mem_bwe  = cpu_bwe;
        end else if (grant_vid) begin
            mem_addr = vid_addr;
        end

        addr_d     = mem_addr;
        cpu_ack_d  = grant_cpu;
        vid_ack_d  = grant_vid;
        last_vid_d = last_vid_q;
        if (grant_vid) begin
            last_vid_d = 1'b1;
        end else if (grant_cpu) begin
            last_vid_d = 1'b0;
        end
    end

    // last_vid resets high so the first contended cycle goes to the CPU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            last_vid_q <= 1'b1;
            addr_q     <= '0;
        end else begin
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
            last_vid_q <= last_vid_d;
            addr_q     <= addr_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign cpu_rdata = cpu_ack_q ? mem_dout : 16'h0000;
    assign vid_rdata = vid_ack_q ? mem_dout : 16'h0000;

endmodule
